// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM stage: FSM state and access-size encodings.
// The alignment helper is only referenced when MEM_ALIGN_CHECK_EN is defined.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic misaligned(
        input logic [3:0] mask,
        input logic [1:0] off
    );
        return ((mask == MASK_H) && off[0]) ||
               ((mask == MASK_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane steering: store shift/strobe generation and
// load byte/half/word extraction with sign or zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic [3:0]  rmask,
    input  logic [31:0] rdata,
    input  logic        load_signed,
    output logic [3:0]  strb,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [4:0]  sh_amt;
    logic [31:0] sh;

    assign sh_amt   = {off, 3'b000};
    assign strb     = wmask << off;
    assign wdata_sh = wdata << sh_amt;
    assign sh       = rdata >> sh_amt;

    always_comb begin
        rdata_ext = sh;
        unique case (rmask)
            MASK_B:  rdata_ext = {{24{load_signed & sh[7]}}, sh[7:0]};
            MASK_H:  rdata_ext = {{16{load_signed & sh[15]}}, sh[15:0]};
            default: rdata_ext = sh;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: one load/store per bundle on the dm_req/dm_ack bus, registered WB bundle.
// Define MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses without a bus request.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] regcData_i,
    input  logic [4:0]  regcAddr_i,
    input  logic        regcWr_i,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memData_i,
    input  logic        readWr_i,
    input  logic        writeWr_i,
    input  logic [3:0]  rmask_i,
    input  logic [3:0]  wmask_i,
    input  logic        load_signed_i,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_regcData,
    output logic [4:0]  wb_regcAddr,
    output logic        wb_regcWr,
    output logic        mem_err
);

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  off_q;
    logic [3:0]  rmask_q;
    logic        sign_q;
    logic        we_q;
    logic        wr_q;
    logic        err_q;

    logic        accept;
    logic        mem_op;
    logic        misalign;
    logic [1:0]  lane_off;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    // DONE counts as "WB slot free" when wb_ready, so bundles flow back-to-back
    assign in_ready = ((state == IDLE) || (state == DONE)) &&
                      (!wb_valid || wb_ready);
    assign accept   = in_valid && in_ready;
    assign mem_op   = readWr_i || writeWr_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op &&
        misaligned(writeWr_i ? wmask_i : rmask_i, memAddr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Store lanes come from the incoming bundle, load lanes from the latched one
    assign lane_off = (state == WAIT) ? off_q : memAddr_i[1:0];

    mem_lane_align u_align (
        .off         (lane_off),
        .wmask       (wmask_i),
        .wdata       (memData_i),
        .rmask       (rmask_q),
        .rdata       (dm_rdata),
        .load_signed (sign_q),
        .strb        (st_strb),
        .wdata_sh    (st_data),
        .rdata_ext   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            off_q       <= 2'b00;
            rmask_q     <= 4'b0000;
            sign_q      <= 1'b0;
            we_q        <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 32'd0;
            dm_wdata    <= 32'd0;
            dm_wstrb    <= 4'd0;
            wb_valid    <= 1'b0;
            wb_regcData <= 32'd0;
            wb_regcAddr <= 5'd0;
            wb_regcWr   <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            unique case (state)
                WAIT: begin
                    if (dm_ack) begin
                        state     <= DONE;
                        dm_req    <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_regcWr <= wr_q && !we_q;
                        mem_err   <= err_q;
                        if (!we_q) begin
                            wb_regcData <= ld_data;
                        end
                    end else if (cnt == TO_LAST) begin
                        state     <= DONE;
                        dm_req    <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_regcWr <= 1'b0;
                        mem_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (wb_ready) begin
                        state     <= IDLE;
                        wb_valid  <= 1'b0;
                        wb_regcWr <= 1'b0;
                        mem_err   <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                off_q       <= memAddr_i[1:0];
                rmask_q     <= rmask_i;
                sign_q      <= load_signed_i;
                we_q        <= writeWr_i;
                wr_q        <= regcWr_i;
                err_q       <= readWr_i && writeWr_i;
                cnt         <= 8'd0;
                wb_regcData <= regcData_i;
                wb_regcAddr <= regcAddr_i;
                if (!mem_op) begin
                    state     <= DONE;
                    wb_valid  <= 1'b1;
                    wb_regcWr <= regcWr_i;
                    mem_err   <= 1'b0;
                end else if (misalign) begin
                    state     <= DONE;
                    wb_valid  <= 1'b1;
                    wb_regcWr <= 1'b0;
                    mem_err   <= 1'b1;
                end else begin
                    state     <= WAIT;
                    wb_valid  <= 1'b0;
                    wb_regcWr <= 1'b0;
                    mem_err   <= 1'b0;
                    dm_req    <= 1'b1;
                    dm_we     <= writeWr_i;
                    dm_addr   <= {memAddr_i[31:2], 2'b00};
                    dm_wdata  <= writeWr_i ? st_data : 32'd0;
                    dm_wstrb  <= writeWr_i ? st_strb : 4'd0;
                end
            end
        end
    end

endmodule
